// File: rtl/alu_dispatch.sv
// alu_dispatch: issue stage that decodes RV64I OP / OP-IMM (and optionally OP-32 / OP-IMM-32)
//   into ALU op + operands, holds alu_enable for ALU_LAT+1 cycles, then offers the result on a writeback port.
// Latency: accept at edge T0, EXEC cycles T0+1..T0+ALU_LAT+1, wb_valid from T0+ALU_LAT+2; one instruction in flight.
// Backpressure: in_ready is low outside IDLE; wb_valid/wb_data/wb_rd_addr hold until wb_ready.
//
// Ports:
//   clk, rst                      sole clock (rising edge), synchronous active-high reset
//   in_valid/in_ready/in_instr    instruction handshake and raw instruction word
//   in_rs1_val, in_rs2_val        register operand values
//   alu_op/alu_rs1/alu_rs2        ALU op code and operands, stable while alu_enable is high
//   alu_enable, alu_rd            ALU enable and ALU result
//   wb_valid/wb_ready             writeback handshake to the register file
//   wb_rd_addr, wb_data           destination register and result
//   illegal                       one-cycle pulse on an undecodable instruction
//
// Optional feature: define ALU_DISPATCH_W32_EN to decode OP-32 / OP-IMM-32 into ops 10..14.
// Without it those opcodes are illegal and ops 10..14 are never produced.

module alu_dispatch #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [63:0] in_rs1_val,
  input  logic [63:0] in_rs2_val,
  output logic [4:0]  alu_op,
  output logic [63:0] alu_rs1,
  output logic [63:0] alu_rs2,
  output logic        alu_enable,
  input  logic [63:0] alu_rd,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd_addr,
  output logic [63:0] wb_data,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

`ifdef ALU_DISPATCH_W32_EN
  localparam logic [4:0] OP_ADDW = 5'd10;
  localparam logic [4:0] OP_SUBW = 5'd11;
  localparam logic [4:0] OP_SLLW = 5'd12;
  localparam logic [4:0] OP_SRLW = 5'd13;
  localparam logic [4:0] OP_SRAW = 5'd14;

  localparam logic [6:0] OPC_OP32  = 7'b0111011;
  localparam logic [6:0] OPC_IMM32 = 7'b0011011;
`endif

  // Counter compares against the last EXEC cycle index (0..7).
  localparam logic [2:0] LAST_CNT = 3'(ALU_LAT);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [4:0]  alu_op_q;
  logic [63:0] alu_rs1_q;
  logic [63:0] alu_rs2_q;
  logic        alu_enable_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_addr_q;
  logic [63:0] wb_data_q;
  logic        illegal_q;

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] imm_sext;
  logic        dec_legal_d;
  logic [4:0]  dec_op_d;
  logic [63:0] dec_rs2_d;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign imm_sext = {{52{in_instr[31]}}, in_instr[31:20]};

  // Register-index field of rs1 is resolved upstream; the value arrives on in_rs1_val.
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^in_instr[19:15];

  always_comb begin
    dec_legal_d = 1'b1;
    dec_op_d    = OP_ADD;
    dec_rs2_d   = in_rs2_val;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: dec_op_d = OP_ADD;
            3'b001: dec_op_d = OP_SLL;
            3'b010: dec_op_d = OP_SLT;
            3'b011: dec_op_d = OP_SLTU;
            3'b100: dec_op_d = OP_XOR;
            3'b101: dec_op_d = OP_SRL;
            3'b110: dec_op_d = OP_OR;
            3'b111: dec_op_d = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_op_d = OP_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_op_d = OP_SRA;
        end else begin
          dec_legal_d = 1'b0;
        end
      end
      OPC_IMM: begin
        dec_rs2_d = imm_sext;
        case (funct3)
          3'b000: dec_op_d = OP_ADD;
          3'b010: dec_op_d = OP_SLT;
          3'b011: dec_op_d = OP_SLTU;
          3'b100: dec_op_d = OP_XOR;
          3'b110: dec_op_d = OP_OR;
          3'b111: dec_op_d = OP_AND;
          // 64-bit shifts: imm[5:0] is shamt, imm[11:6] selects the shift kind.
          3'b001: begin
            dec_op_d = OP_SLL;
            if (in_instr[31:26] != 6'b000000) dec_legal_d = 1'b0;
          end
          3'b101: begin
            if (in_instr[31:26] == 6'b000000) begin
              dec_op_d = OP_SRL;
            end else if (in_instr[31:26] == 6'b010000) begin
              dec_op_d = OP_SRA;
            end else begin
              dec_legal_d = 1'b0;
            end
          end
        endcase
      end
`ifdef ALU_DISPATCH_W32_EN
      OPC_OP32: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_op_d = OP_ADDW;
            3'b001:  dec_op_d = OP_SLLW;
            3'b101:  dec_op_d = OP_SRLW;
            default: dec_legal_d = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  dec_op_d = OP_SUBW;
            3'b101:  dec_op_d = OP_SRAW;
            default: dec_legal_d = 1'b0;
          endcase
        end else begin
          dec_legal_d = 1'b0;
        end
      end
      OPC_IMM32: begin
        dec_rs2_d = imm_sext;
        case (funct3)
          3'b000: dec_op_d = OP_ADDW;
          // 32-bit shifts: funct7 covers shamt bit 5, so a set bit 5 fails both matches.
          3'b001: begin
            dec_op_d = OP_SLLW;
            if (funct7 != 7'b0000000) dec_legal_d = 1'b0;
          end
          3'b101: begin
            if (funct7 == 7'b0000000) begin
              dec_op_d = OP_SRLW;
            end else if (funct7 == 7'b0100000) begin
              dec_op_d = OP_SRAW;
            end else begin
              dec_legal_d = 1'b0;
            end
          end
          default: dec_legal_d = 1'b0;
        endcase
      end
`endif
      default: dec_legal_d = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      alu_op_q     <= 5'd0;
      alu_rs1_q    <= 64'd0;
      alu_rs2_q    <= 64'd0;
      alu_enable_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_addr_q <= 5'd0;
      wb_data_q    <= 64'd0;
      illegal_q    <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            alu_op_q     <= dec_op_d;
            alu_rs1_q    <= in_rs1_val;
            alu_rs2_q    <= dec_rs2_d;
            wb_rd_addr_q <= in_instr[11:7];
            cnt_q        <= 3'd0;
            if (dec_legal_d) begin
              alu_enable_q <= 1'b1;
              state_q      <= EXEC;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == LAST_CNT) begin
            wb_data_q    <= alu_rd;
            alu_enable_q <= 1'b0;
            // Writes to x0 are dropped here rather than offered to the register file.
            if (wb_rd_addr_q != 5'd0) begin
              wb_valid_q <= 1'b1;
              state_q    <= WB;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready depends only on state and rst, never on wb_ready.
  assign in_ready   = (state_q == IDLE) && !rst;
  assign alu_op     = alu_op_q;
  assign alu_rs1    = alu_rs1_q;
  assign alu_rs2    = alu_rs2_q;
  assign alu_enable = alu_enable_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd_addr = wb_rd_addr_q;
  assign wb_data    = wb_data_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: self-checking bench for alu_dispatch with a latency-accurate ALU stand-in.
// Latency: checks accept-to-writeback timing against ALU_LAT.
// Backpressure: exercises stalled writeback and back-to-back issue.

module tb_alu_dispatch;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_rs1_val;
  logic [63:0] in_rs2_val;
  logic [4:0]  alu_op;
  logic [63:0] alu_rs1;
  logic [63:0] alu_rs2;
  logic        alu_enable;
  logic [63:0] alu_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd_addr;
  logic [63:0] wb_data;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  alu_dispatch #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_enable(alu_enable), .alu_rd(alu_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each ALU op code.
  function automatic logic [63:0] sem(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] w;
    w = 32'd0;
    sem = 64'd0;
    case (op)
      5'd0:  sem = a + b;
      5'd1:  sem = a - b;
      5'd2:  sem = a << b[5:0];
      5'd3:  sem = {63'd0, $signed(a) < $signed(b)};
      5'd4:  sem = {63'd0, a < b};
      5'd5:  sem = a ^ b;
      5'd6:  sem = a >> b[5:0];
      5'd7:  sem = $signed(a) >>> b[5:0];
      5'd8:  sem = a | b;
      5'd9:  sem = a & b;
      5'd10: begin w = a[31:0] + b[31:0];          sem = {{32{w[31]}}, w}; end
      5'd11: begin w = a[31:0] - b[31:0];          sem = {{32{w[31]}}, w}; end
      5'd12: begin w = a[31:0] << b[4:0];          sem = {{32{w[31]}}, w}; end
      5'd13: begin w = a[31:0] >> b[4:0];          sem = {{32{w[31]}}, w}; end
      5'd14: begin w = $signed(a[31:0]) >>> b[4:0]; sem = {{32{w[31]}}, w}; end
      default: sem = 64'd0;
    endcase
  endfunction

  // ALU stand-in: only the cycle with ALU_LAT prior enabled cycles carries the real result.
  int en_cnt = 0;
  always @(posedge clk) en_cnt <= alu_enable ? en_cnt + 1 : 0;
  assign alu_rd = (alu_enable && en_cnt == LAT) ? sem(alu_op, alu_rs1, alu_rs2)
                                                : 64'hBADC_0FFE_E0DD_F00D;

  // Reference decode from the RV64I instruction tables.
  function automatic void ref_model(input logic [31:0] ins, input logic [63:0] b,
                                    output logic legal, output logic [4:0] op, output logic [63:0] o2);
    logic [4:0]  r_tbl [8];
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    r_tbl = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    f3 = ins[14:12];
    f7 = ins[31:25];
    imm = {{52{ins[31]}}, ins[31:20]};
    legal = 1'b0; op = 5'd0; o2 = b;
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h00) begin legal = 1'b1; op = r_tbl[f3]; end
        else if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1'b1; op = 5'd1; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin legal = 1'b1; op = 5'd7; end
      end
      7'h13: begin
        o2 = imm;
        if (f3 == 3'd1) begin legal = (ins[31:26] == 6'h00); op = 5'd2; end
        else if (f3 == 3'd5) begin
          legal = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h10);
          op = ins[30] ? 5'd7 : 5'd6;
        end else begin legal = 1'b1; op = r_tbl[f3]; end
      end
`ifdef ALU_DISPATCH_W32_EN
      7'h3B: begin
        if (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) begin
          legal = 1'b1; op = (f3 == 3'd0) ? 5'd10 : (f3 == 3'd1) ? 5'd12 : 5'd13;
        end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          legal = 1'b1; op = (f3 == 3'd0) ? 5'd11 : 5'd14;
        end
      end
      7'h1B: begin
        o2 = imm;
        if (f3 == 3'd0) begin legal = 1'b1; op = 5'd10; end
        else if (f3 == 3'd1) begin legal = (f7 == 7'h00); op = 5'd12; end
        else if (f3 == 3'd5) begin legal = (f7 == 7'h00) || (f7 == 7'h20); op = ins[30] ? 5'd14 : 5'd13; end
      end
`endif
      default: legal = 1'b0;
    endcase
  endfunction

  // Drives one instruction with wb_ready=1 and observes LAT+6 cycles. Entered and left at a negedge in IDLE.
  task automatic issue(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                       output logic [4:0] op_o, output logic [63:0] r1_o, output logic [63:0] r2_o,
                       output logic ill1, output int ill_cyc, output int en_cyc, output int rdy_low,
                       output int wb_cyc, output int wb_n, output logic [4:0] addr_o, output logic [63:0] data_o);
    in_instr = ins; in_rs1_val = a; in_rs2_val = b; in_valid = 1'b1; wb_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_o = alu_op; r1_o = alu_rs1; r2_o = alu_rs2; ill1 = illegal;
    ill_cyc = 0; en_cyc = 0; rdy_low = 0; wb_cyc = -1; wb_n = 0; addr_o = 5'd0; data_o = 64'd0;
    for (int k = 1; k <= LAT + 6; k++) begin
      if (k > 1) @(negedge clk);
      if (illegal)    ill_cyc++;
      if (alu_enable) en_cyc++;
      if (!in_ready)  rdy_low++;
      if (wb_valid) begin
        wb_n++;
        if (wb_cyc < 0) begin wb_cyc = k; addr_o = wb_rd_addr; data_o = wb_data; end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
    in_instr = 32'd0; in_rs1_val = 64'd0; in_rs2_val = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || alu_enable !== 1'b0 || alu_op !== 5'd0 || alu_rs1 !== 64'd0 ||
        alu_rs2 !== 64'd0 || wb_valid !== 1'b0 || wb_rd_addr !== 5'd0 || wb_data !== 64'd0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: rdy=%b en=%b op=%0d rs1=%h rs2=%h wbv=%b addr=%0d data=%h ill=%b, required all 0",
               in_ready, alu_enable, alu_op, alu_rs1, alu_rs2, wb_valid, wb_rd_addr, wb_data, illegal);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0 || alu_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: rdy=%b wbv=%b en=%b, required 1 0 0", in_ready, wb_valid, alu_enable);
    end
  endtask

  task automatic test_directed;
    logic [4:0] op; logic [63:0] r1, r2, d; logic [4:0] ad; logic ill1;
    int ic, ec, rl, wc, wn;
    logic [63:0] a;
    issue(32'h002081B3, 64'd5, 64'd7, op, r1, r2, ill1, ic, ec, rl, wc, wn, ad, d);
    total++;
    if (op !== 5'd0 || r1 !== 64'd5 || r2 !== 64'd7) begin
      bad++; $display("FAIL add_issue: op=%0d rs1=%0d rs2=%0d, required 0 5 7", op, r1, r2);
    end
    total++;
    if (wc !== LAT + 2 || wn !== 1 || ad !== 5'd3 || d !== 64'd12) begin
      bad++; $display("FAIL add_wb: cyc=%0d n=%0d addr=%0d data=%0d, required %0d 1 3 12", wc, wn, ad, d, LAT + 2);
    end
    total++;
    if (ec !== LAT + 1 || rl !== LAT + 2 || ic !== 0) begin
      bad++; $display("FAIL add_occupancy: en=%0d rdy_low=%0d ill=%0d, required %0d %0d 0", ec, rl, ic, LAT + 1, LAT + 2);
    end
    issue(32'h40208133, 64'd3, 64'd10, op, r1, r2, ill1, ic, ec, rl, wc, wn, ad, d);
    total++;
    if (op !== 5'd1 || d !== 64'hFFFF_FFFF_FFFF_FFF9 || ad !== 5'd2 || wc !== LAT + 2) begin
      bad++; $display("FAIL sub: op=%0d data=%h addr=%0d cyc=%0d, required 1 fffffffffffffff9 2 %0d", op, d, ad, wc, LAT + 2);
    end
    a = {$urandom, $urandom};
    issue(32'hFFF00293, a, {$urandom, $urandom}, op, r1, r2, ill1, ic, ec, rl, wc, wn, ad, d);
    total++;
    if (op !== 5'd0 || r2 !== 64'hFFFF_FFFF_FFFF_FFFF || d !== a - 64'd1 || ad !== 5'd5) begin
      bad++; $display("FAIL addi: op=%0d rs2=%h data=%h addr=%0d, required 0 ffffffffffffffff %h 5", op, r2, d, ad, a - 64'd1);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] tbl [5];
    logic [4:0] op; logic [63:0] r1, r2, d; logic [4:0] ad; logic ill1;
    int ic, ec, rl, wc, wn;
    // zero word, MUL, funct7=0100000 with SLL, SLLI with imm[11:6]!=0, SRAI with bad imm[11:6]
    tbl = '{32'h0000_0000, 32'h0220_81B3, 32'h4020_91B3, 32'h8000_9293, 32'hC000_D293};
    foreach (tbl[i]) begin
      issue(tbl[i], {$urandom, $urandom}, {$urandom, $urandom}, op, r1, r2, ill1, ic, ec, rl, wc, wn, ad, d);
      total++;
      if (ill1 !== 1'b1 || ic !== 1 || ec !== 0 || wn !== 0 || rl !== 0) begin
        bad++;
        $display("FAIL illegal_%0d: instr=%h ill1=%b ill_cyc=%0d en=%0d wb=%0d rdy_low=%0d, required 1 1 0 0 0",
                 i, tbl[i], ill1, ic, ec, wn, rl);
      end
    end
  endtask

  task automatic test_rd0;
    logic [4:0] op; logic [63:0] r1, r2, d; logic [4:0] ad; logic ill1;
    int ic, ec, rl, wc, wn;
    issue(32'h0020_8033, 64'd1, 64'd2, op, r1, r2, ill1, ic, ec, rl, wc, wn, ad, d);
    total++;
    if (ec !== LAT + 1 || wn !== 0 || rl !== LAT + 1 || ic !== 0) begin
      bad++; $display("FAIL rd0: en=%0d wb=%0d rdy_low=%0d ill=%0d, required %0d 0 %0d 0", ec, wn, rl, ic, LAT + 1, LAT + 1);
    end
  endtask

  task automatic test_wb_stall;
    logic [63:0] a, b, d0; logic [4:0] ad0;
    int n;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    wb_ready = 1'b0;
    in_instr = 32'h002081B3; in_rs1_val = a; in_rs2_val = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!wb_valid && n < 20) begin @(negedge clk); n++; end
    total++;
    if (wb_valid !== 1'b1 || n !== LAT + 1) begin
      bad++; $display("FAIL stall_wb_rise: wbv=%b waited=%0d, required 1 %0d", wb_valid, n, LAT + 1);
    end
    d0 = wb_data; ad0 = wb_rd_addr;
    total++;
    if (d0 !== a + b || ad0 !== 5'd3) begin
      bad++; $display("FAIL stall_data: data=%h addr=%0d, required %h 3", d0, ad0, a + b);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b1 || wb_data !== d0 || wb_rd_addr !== ad0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold_%0d: wbv=%b data=%h addr=%0d rdy=%b, required 1 %h %0d 0",
                        c, wb_valid, wb_data, wb_rd_addr, in_ready, d0, ad0);
      end
    end
    wb_ready = 1'b1;
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release: wbv=%b rdy=%b, required 0 1", wb_valid, in_ready);
    end
  endtask

  task automatic test_reset_exec;
    int seen;
    wb_ready = 1'b1;
    in_instr = 32'h002081B3; in_rs1_val = 64'd9; in_rs2_val = 64'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (alu_enable !== 1'b1) begin bad++; $display("FAIL rexec_enable: en=%b, required 1", alu_enable); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (alu_enable !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b0 || alu_op !== 5'd0 || wb_data !== 64'd0) begin
      bad++; $display("FAIL rexec_reset: en=%b wbv=%b rdy=%b op=%0d data=%h, required 0 0 0 0 0",
                      alu_enable, wb_valid, in_ready, alu_op, wb_data);
    end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      if (wb_valid || alu_enable) seen++;
    end
    total++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rexec_after: active_cycles=%0d rdy=%b, required 0 1", seen, in_ready);
    end
  endtask

  task automatic test_w32;
    logic [4:0] op; logic [63:0] r1, r2, d; logic [4:0] ad; logic ill1;
    int ic, ec, rl, wc, wn;
    logic [63:0] a, b, e;
    logic [31:0] s;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    s = a[31:0] + b[31:0];
    e = {{32{s[31]}}, s};
    issue(32'h002081BB, a, b, op, r1, r2, ill1, ic, ec, rl, wc, wn, ad, d);
    total++;
`ifdef ALU_DISPATCH_W32_EN
    if (op !== 5'd10 || d !== e || ad !== 5'd3 || wc !== LAT + 2 || ic !== 0) begin
      bad++; $display("FAIL addw: op=%0d data=%h addr=%0d cyc=%0d ill=%0d, required 10 %h 3 %0d 0", op, d, ad, wc, ic, e, LAT + 2);
    end
`else
    if (ic !== 1 || ec !== 0 || wn !== 0) begin
      bad++; $display("FAIL addw_off: ill=%0d en=%0d wb=%0d (addw %h), required 1 0 0", ic, ec, wn, e);
    end
`endif
    // SLLIW with shamt bit 5 set is illegal in every build.
    issue(32'h0200_929B, a, b, op, r1, r2, ill1, ic, ec, rl, wc, wn, ad, d);
    total++;
    if (ic !== 1 || ec !== 0 || wn !== 0) begin
      bad++; $display("FAIL slliw_shamt5: ill=%0d en=%0d wb=%0d, required 1 0 0", ic, ec, wn);
    end
  endtask

  task automatic test_random;
    logic [4:0] op; logic [63:0] r1, r2, d; logic [4:0] ad; logic ill1;
    int ic, ec, rl, wc, wn;
    logic [31:0] ins; logic [63:0] a, b;
    logic legal; logic [4:0] eop; logic [63:0] eo2, ed;
    for (int it = 0; it < 60; it++) begin
      ins = $urandom;
      case ($urandom_range(0, 4))
        0: ins[6:0] = 7'h33;
        1: ins[6:0] = 7'h13;
        2: ins[6:0] = 7'h3B;
        3: ins[6:0] = 7'h1B;
        default: ;
      endcase
      if ($urandom_range(0, 3) != 0) ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      ref_model(ins, b, legal, eop, eo2);
      ed = sem(eop, a, eo2);
      issue(ins, a, b, op, r1, r2, ill1, ic, ec, rl, wc, wn, ad, d);
      total++;
      if (legal) begin
        if (op !== eop || r1 !== a || r2 !== eo2 || ic !== 0 || ec !== LAT + 1 ||
            (ins[11:7] != 5'd0 && (wc !== LAT + 2 || wn !== 1 || ad !== ins[11:7] || d !== ed)) ||
            (ins[11:7] == 5'd0 && wn !== 0)) begin
          bad++;
          $display("FAIL rand_%0d: instr=%h op=%0d/%0d rs2=%h/%h data=%h/%h addr=%0d/%0d wbcyc=%0d/%0d en=%0d ill=%0d",
                   it, ins, op, eop, r2, eo2, d, ed, ad, ins[11:7], wc, LAT + 2, ec, ic);
        end
      end else begin
        if (ic !== 1 || ec !== 0 || wn !== 0 || rl !== 0) begin
          bad++;
          $display("FAIL rand_ill_%0d: instr=%h ill=%0d en=%0d wb=%0d rdy_low=%0d, required 1 0 0 0", it, ins, ic, ec, wn, rl);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc_t[$];
    logic [63:0] ed[$];
    logic [4:0]  ea[$];
    logic [63:0] a, b, nd;
    logic [4:0] rd;
    logic is_xor, acc;
    int n, pops;
    n = 0; pops = 0;
    wb_ready = 1'b1;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; rd = 5'($urandom_range(1, 31)); is_xor = 1'($urandom);
    in_instr = {7'd0, 5'd2, 5'd1, is_xor ? 3'b100 : 3'b000, rd, 7'h33};
    in_rs1_val = a; in_rs2_val = b; nd = is_xor ? (a ^ b) : (a + b);
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (wb_valid) begin
        total++;
        if (ed.size() == 0 || wb_data !== ed[0] || wb_rd_addr !== ea[0]) begin
          bad++; $display("FAIL b2b_wb_%0d: data=%h addr=%0d, required %h %0d", pops, wb_data, wb_rd_addr,
                          (ed.size() != 0) ? ed[0] : 64'd0, (ea.size() != 0) ? ea[0] : 5'd0);
        end
        if (ed.size() != 0) begin void'(ed.pop_front()); void'(ea.pop_front()); end
        pops++;
      end
      acc = in_valid && in_ready;
      if (acc) begin acc_t.push_back(c); ed.push_back(nd); ea.push_back(rd); end
      @(posedge clk); #1;
      if (acc) begin
        n++;
        if (n < 4) begin
          a = {$urandom, $urandom}; b = {$urandom, $urandom}; rd = 5'($urandom_range(1, 31)); is_xor = 1'($urandom);
          in_instr = {7'd0, 5'd2, 5'd1, is_xor ? 3'b100 : 3'b000, rd, 7'h33};
          in_rs1_val = a; in_rs2_val = b; nd = is_xor ? (a ^ b) : (a + b);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    total++;
    if (acc_t.size() != 4 || pops != 4) begin
      bad++; $display("FAIL b2b_count: accepts=%0d writebacks=%0d, required 4 4", acc_t.size(), pops);
    end else begin
      for (int i = 1; i < 4; i++) begin
        total++;
        if (acc_t[i] - acc_t[i-1] != LAT + 3) begin
          bad++; $display("FAIL b2b_spacing_%0d: gap=%0d, required %0d", i, acc_t[i] - acc_t[i-1], LAT + 3);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_rd0();
    test_wb_stall();
    test_reset_exec();
    test_w32();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
